// File: rtl/splash_overlay_if.sv
// Pixel-stream and splash-control bundle between the VGA timing/setter side and
// the splash overlay.
//   master : drives x/y, frameTick, sliceEvent/sliceX/sliceY, splashColor, bgColor;
//            observes splashX/splashY, colorOut, splashActive.
//   slave  : the overlay (direction-reversed view).
interface splash_overlay_if;
  logic [9:0]  x;
  logic [8:0]  y;
  logic        frameTick;
  logic        sliceEvent;
  logic [9:0]  sliceX;
  logic [8:0]  sliceY;
  logic [11:0] splashColor;
  logic [11:0] bgColor;
  logic [9:0]  splashX;
  logic [8:0]  splashY;
  logic [11:0] colorOut;
  logic        splashActive;

  modport master (
    output x, y, frameTick, sliceEvent, sliceX, sliceY, splashColor, bgColor,
    input  splashX, splashY, colorOut, splashActive
  );

  modport slave (
    input  x, y, frameTick, sliceEvent, sliceX, sliceY, splashColor, bgColor,
    output splashX, splashY, colorOut, splashActive
  );
endinterface

// File: rtl/splash_overlay.sv
// Fruit-splash sequencer and compositor. Latches the slice position as a
// clamped sprite corner, arms it on the next frame tick, holds it for LIFETIME
// frames, and composites the setter's colour over the background using an
// in-box flag delayed to match the setter's RAM latency.
//   clk   : pixel clock
//   reset : synchronous, active-high
//   bus   : splash_overlay_if.slave (pixel position, frame/slice events,
//           setter/background colours in; sprite corner, colour, active out)
module splash_overlay #(
  parameter int unsigned SPRITE_SIZE = 50,
  parameter int unsigned LIFETIME    = 30,
  parameter logic [11:0] TRANSPARENT = 12'h000,
  parameter int unsigned RAM_LATENCY = 2
) (
  input  logic             clk,
  input  logic             reset,
  splash_overlay_if.slave  bus
);

  localparam int unsigned HALF  = SPRITE_SIZE / 2;
  localparam int unsigned MAX_X = 640 - SPRITE_SIZE;
  localparam int unsigned MAX_Y = 480 - SPRITE_SIZE;

  typedef enum logic {IDLE, SHOW} state_t;

  state_t     state, state_nxt;
  logic [7:0] cnt, cnt_nxt;
  logic       load_c;

  logic [9:0] pend_x, splash_x;
  logic [8:0] pend_y, splash_y;
  logic       pending;

  logic [10:0] cx_wide_c;
  logic [9:0]  cy_wide_c;
  logic        in_box_c;
  logic [RAM_LATENCY-1:0] in_box_d;
  logic [11:0] color_out;

  // Corner = centre - half size, floored at 0 and kept fully on screen.
  always_comb begin
    cx_wide_c = (11'(bus.sliceX) >= 11'(HALF)) ? 11'(bus.sliceX) - 11'(HALF) : 11'd0;
    if (cx_wide_c > 11'(MAX_X)) cx_wide_c = 11'(MAX_X);
    cy_wide_c = (10'(bus.sliceY) >= 10'(HALF)) ? 10'(bus.sliceY) - 10'(HALF) : 10'd0;
    if (cy_wide_c > 10'(MAX_Y)) cy_wide_c = 10'(MAX_Y);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next state, lifetime counter and corner-load decision.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    load_c    = 1'b0;
    case (state)
      IDLE: begin
        if (bus.frameTick && pending) begin
          load_c    = 1'b1;
          state_nxt = SHOW;
        end
      end
      SHOW: begin
        if (bus.frameTick) begin
          if (pending) begin
            load_c = 1'b1;
          end else begin
            cnt_nxt = cnt - 8'd1;
            if (cnt == 8'd1) state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (load_c) cnt_nxt = 8'(LIFETIME);
  end

  // Pending corner: last slice wins; a coincident tick consumes the old value.
  always_ff @(posedge clk) begin
    if (reset) begin
      pending <= 1'b0;
      pend_x  <= '0;
      pend_y  <= '0;
    end else if (bus.sliceEvent) begin
      pending <= 1'b1;
      pend_x  <= cx_wide_c[9:0];
      pend_y  <= cy_wide_c[8:0];
    end else if (bus.frameTick) begin
      pending <= 1'b0;
    end
  end

  // Displayed corner and counter; the corner only moves on a frame tick.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt      <= '0;
      splash_x <= '0;
      splash_y <= '0;
    end else begin
      cnt <= cnt_nxt;
      if (load_c) begin
        splash_x <= pend_x;
        splash_y <= pend_y;
      end
    end
  end

  always_comb begin
    in_box_c = (state == SHOW)
            && (11'(bus.x) >= 11'(splash_x))
            && (11'(bus.x) <  11'(splash_x) + 11'(SPRITE_SIZE))
            && (10'(bus.y) >= 10'(splash_y))
            && (10'(bus.y) <  10'(splash_y) + 10'(SPRITE_SIZE));
  end

  // In-box delay line aligned to the setter's colour, then compositing register.
  always_ff @(posedge clk) begin
    if (reset) begin
      in_box_d  <= '0;
      color_out <= '0;
    end else begin
      in_box_d[0] <= in_box_c;
      for (int i = 1; i < int'(RAM_LATENCY); i++) in_box_d[i] <= in_box_d[i-1];
      color_out <= (in_box_d[RAM_LATENCY-1] && (bus.splashColor != TRANSPARENT))
                   ? bus.splashColor : bus.bgColor;
    end
  end

  assign bus.splashX      = splash_x;
  assign bus.splashY      = splash_y;
  assign bus.colorOut     = color_out;
  assign bus.splashActive = (state == SHOW);

endmodule

// File: tb/tb_splash_overlay.sv
// Directed bench for splash_overlay (LIFETIME overridden to 3).
module tb_splash_overlay;
  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_bad = 0;
  logic [11:0] got;

  splash_overlay_if bus ();

  splash_overlay #(
    .SPRITE_SIZE(50), .LIFETIME(3), .TRANSPARENT(12'h000), .RAM_LATENCY(2)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk); bus.frameTick = 1'b1;
    @(negedge clk); bus.frameTick = 1'b0;
  endtask

  task automatic slice(input logic [9:0] sx, input logic [8:0] sy);
    @(negedge clk); bus.sliceEvent = 1'b1; bus.sliceX = sx; bus.sliceY = sy;
    @(negedge clk); bus.sliceEvent = 1'b0;
  endtask

  // x/y at cycle 0, setter colours at cycle 2, colorOut sampled after 3rd edge.
  task automatic pixel(input logic [9:0] px, input logic [8:0] py,
                       input logic [11:0] sc, input logic [11:0] bg,
                       output logic [11:0] res);
    @(negedge clk); bus.x = px; bus.y = py; bus.splashColor = 12'hBAD; bus.bgColor = 12'h5A5;
    @(negedge clk); bus.x = 10'd0; bus.y = 9'd0;
    @(negedge clk); bus.splashColor = sc; bus.bgColor = bg;
    @(negedge clk); res = bus.colorOut;
    bus.splashColor = 12'hBAD; bus.bgColor = 12'h5A5;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.x = '0; bus.y = '0; bus.frameTick = 1'b0; bus.sliceEvent = 1'b0;
    bus.sliceX = '0; bus.sliceY = '0; bus.splashColor = '0; bus.bgColor = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    n_cmp++; if (bus.splashX !== 10'd0) begin n_bad++; $display("FAIL rst_x got %0d want 0", bus.splashX); end
    n_cmp++; if (bus.splashY !== 9'd0) begin n_bad++; $display("FAIL rst_y got %0d want 0", bus.splashY); end
    n_cmp++; if (bus.colorOut !== 12'h000) begin n_bad++; $display("FAIL rst_color got %h want 000", bus.colorOut); end
    n_cmp++; if (bus.splashActive !== 1'b0) begin n_bad++; $display("FAIL rst_active got %b want 0", bus.splashActive); end
  endtask

  task automatic test_arm();
    slice(10'd300, 9'd200);
    n_cmp++; if (bus.splashActive !== 1'b0) begin n_bad++; $display("FAIL arm_pre_active got %b want 0", bus.splashActive); end
    tick();
    n_cmp++; if (bus.splashActive !== 1'b1) begin n_bad++; $display("FAIL arm_active got %b want 1", bus.splashActive); end
    n_cmp++; if (bus.splashX !== 10'd275) begin n_bad++; $display("FAIL arm_x got %0d want 275", bus.splashX); end
    n_cmp++; if (bus.splashY !== 9'd175) begin n_bad++; $display("FAIL arm_y got %0d want 175", bus.splashY); end
    pixel(10'd275, 9'd175, 12'hFA0, 12'h123, got);
    n_cmp++; if (got !== 12'hFA0) begin n_bad++; $display("FAIL arm_corner_px got %h want FA0", got); end
    pixel(10'd325, 9'd175, 12'hFA0, 12'h0F0, got);
    n_cmp++; if (got !== 12'h0F0) begin n_bad++; $display("FAIL arm_right_edge got %h want 0F0", got); end
    pixel(10'd324, 9'd224, 12'hABC, 12'h0F0, got);
    n_cmp++; if (got !== 12'hABC) begin n_bad++; $display("FAIL arm_last_px got %h want ABC", got); end
    pixel(10'd275, 9'd225, 12'hABC, 12'h0F0, got);
    n_cmp++; if (got !== 12'h0F0) begin n_bad++; $display("FAIL arm_bottom_edge got %h want 0F0", got); end
  endtask

  task automatic test_transparent();
    pixel(10'd300, 9'd200, 12'h000, 12'h35C, got);
    n_cmp++; if (got !== 12'h35C) begin n_bad++; $display("FAIL transparent got %h want 35C", got); end
  endtask

  task automatic test_lifetime();
    tick();
    n_cmp++; if (bus.splashActive !== 1'b1) begin n_bad++; $display("FAIL life_t1 got %b want 1", bus.splashActive); end
    tick();
    n_cmp++; if (bus.splashActive !== 1'b1) begin n_bad++; $display("FAIL life_t2 got %b want 1", bus.splashActive); end
    tick();
    n_cmp++; if (bus.splashActive !== 1'b0) begin n_bad++; $display("FAIL life_t3 got %b want 0", bus.splashActive); end
    pixel(10'd300, 9'd200, 12'hFA0, 12'h35C, got);
    n_cmp++; if (got !== 12'h35C) begin n_bad++; $display("FAIL life_expired_px got %h want 35C", got); end
  endtask

  task automatic test_clamp();
    slice(10'd10, 9'd5);
    tick();
    n_cmp++; if (bus.splashX !== 10'd0 || bus.splashY !== 9'd0) begin n_bad++; $display("FAIL clamp_low got %0d,%0d want 0,0", bus.splashX, bus.splashY); end
    slice(10'd635, 9'd478);
    tick();
    n_cmp++; if (bus.splashX !== 10'd590 || bus.splashY !== 9'd430) begin n_bad++; $display("FAIL clamp_high got %0d,%0d want 590,430", bus.splashX, bus.splashY); end
    pixel(10'd639, 9'd479, 12'hF00, 12'h00F, got);
    n_cmp++; if (got !== 12'hF00) begin n_bad++; $display("FAIL clamp_br_px got %h want F00", got); end
    pixel(10'd589, 9'd479, 12'hF00, 12'h00F, got);
    n_cmp++; if (got !== 12'h00F) begin n_bad++; $display("FAIL clamp_left_px got %h want 00F", got); end
    slice(10'd24, 9'd24);
    tick();
    n_cmp++; if (bus.splashX !== 10'd0 || bus.splashY !== 9'd0) begin n_bad++; $display("FAIL clamp_sat got %0d,%0d want 0,0", bus.splashX, bus.splashY); end
    repeat (3) tick();
    n_cmp++; if (bus.splashActive !== 1'b0) begin n_bad++; $display("FAIL clamp_drain got %b want 0", bus.splashActive); end
  endtask

  task automatic test_overwrite();
    slice(10'd100, 9'd100);
    slice(10'd400, 9'd300);
    tick();
    n_cmp++; if (bus.splashX !== 10'd375 || bus.splashY !== 9'd275) begin n_bad++; $display("FAIL ovw_corner got %0d,%0d want 375,275", bus.splashX, bus.splashY); end
    slice(10'd50, 9'd50);
    repeat (4) @(negedge clk);
    n_cmp++; if (bus.splashX !== 10'd375) begin n_bad++; $display("FAIL ovw_midframe got %0d want 375", bus.splashX); end
    tick();
    n_cmp++; if (bus.splashX !== 10'd25 || bus.splashY !== 9'd25) begin n_bad++; $display("FAIL ovw_restart got %0d,%0d want 25,25", bus.splashX, bus.splashY); end
    tick(); tick();
    n_cmp++; if (bus.splashActive !== 1'b1) begin n_bad++; $display("FAIL ovw_reload got %b want 1", bus.splashActive); end
    tick();
    n_cmp++; if (bus.splashActive !== 1'b0) begin n_bad++; $display("FAIL ovw_expire got %b want 0", bus.splashActive); end
  endtask

  task automatic test_simultaneous();
    @(negedge clk);
    bus.sliceEvent = 1'b1; bus.frameTick = 1'b1; bus.sliceX = 10'd200; bus.sliceY = 9'd150;
    @(negedge clk);
    bus.sliceEvent = 1'b0; bus.frameTick = 1'b0;
    n_cmp++; if (bus.splashActive !== 1'b0) begin n_bad++; $display("FAIL sim_same_tick got %b want 0", bus.splashActive); end
    tick();
    n_cmp++; if (bus.splashActive !== 1'b1) begin n_bad++; $display("FAIL sim_next_tick got %b want 1", bus.splashActive); end
    n_cmp++; if (bus.splashX !== 10'd175 || bus.splashY !== 9'd125) begin n_bad++; $display("FAIL sim_corner got %0d,%0d want 175,125", bus.splashX, bus.splashY); end
    @(negedge clk);
    bus.sliceEvent = 1'b1; bus.frameTick = 1'b1; bus.sliceX = 10'd60; bus.sliceY = 9'd60;
    @(negedge clk);
    bus.sliceEvent = 1'b0; bus.frameTick = 1'b0;
    n_cmp++; if (bus.splashX !== 10'd175) begin n_bad++; $display("FAIL sim_show_hold got %0d want 175", bus.splashX); end
    tick();
    n_cmp++; if (bus.splashX !== 10'd35 || bus.splashY !== 9'd35) begin n_bad++; $display("FAIL sim_show_arm got %0d,%0d want 35,35", bus.splashX, bus.splashY); end
  endtask

  task automatic test_reset_mid();
    slice(10'd300, 9'd200);
    pixel(10'd40, 9'd40, 12'hABC, 12'h111, got);
    n_cmp++; if (got !== 12'hABC) begin n_bad++; $display("FAIL rmid_pre_px got %h want ABC", got); end
    @(negedge clk); bus.x = 10'd40; bus.y = 9'd40;
    @(negedge clk); reset = 1'b1; bus.x = 10'd0; bus.y = 9'd0;
    @(negedge clk);
    n_cmp++; if (bus.splashActive !== 1'b0) begin n_bad++; $display("FAIL rmid_active got %b want 0", bus.splashActive); end
    n_cmp++; if (bus.colorOut !== 12'h000) begin n_bad++; $display("FAIL rmid_color got %h want 000", bus.colorOut); end
    reset = 1'b0; bus.splashColor = 12'hABC; bus.bgColor = 12'h111;
    @(negedge clk);
    n_cmp++; if (bus.colorOut !== 12'h111) begin n_bad++; $display("FAIL rmid_delay_clr got %h want 111", bus.colorOut); end
    tick();
    n_cmp++; if (bus.splashActive !== 1'b0) begin n_bad++; $display("FAIL rmid_no_arm got %b want 0", bus.splashActive); end
  endtask

  initial begin
    test_reset();
    test_arm();
    test_transparent();
    test_lifetime();
    test_clamp();
    test_overwrite();
    test_simultaneous();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/splash_overlay.md
# splash_overlay

Sequences and composites a 50x50 fruit-splash sprite onto the VGA pixel stream. On a slice event it latches the splash position, holds it stable for whole frames for a programmable lifetime, and drives the sprite top-left coordinate into the splash image setter. Each pixel, it either passes the setter's 12-bit palette colour or the background colour, with the in-box flag delayed to match the setter's 2-cycle RAM latency. It sits directly downstream of the splash image setter and upstream of the VGA colour output register.

## Interface
- SPRITE_SIZE, 50: sprite edge in pixels.
- LIFETIME, 30: frames the splash stays visible after it is armed (1..255).
- TRANSPARENT, 12'h000: sprite colour treated as see-through.
- RAM_LATENCY, 2: clocks from x/y to the setter's colour output.
- clk  in  1  pixel-domain clock.
- reset  in  1  synchronous, active-high.
- x  in  10  current pixel column (0..639).
- y  in  9  current pixel row (0..479).
- frameTick  in  1  single-cycle pulse at start of vertical blanking.
- sliceEvent  in  1  single-cycle pulse: fruit sliced.
- sliceX  in  10  slice centre column, sampled with sliceEvent.
- sliceY  in  9  slice centre row, sampled with sliceEvent.
- splashColor  in  12  colour from the splash image setter, RAM_LATENCY after x/y.
- bgColor  in  12  background colour, aligned with splashColor.
- splashX  out  10  sprite top-left column to the image setter.
- splashY  out  9  sprite top-left row to the image setter.
- colorOut  out  12  composited pixel, registered.
- splashActive  out  1  high while the splash is displayed.

## Operation
- Reset values: splashX=0, splashY=0, colorOut=0, splashActive=0, pending=0, frame counter=0, state IDLE.
- Corner computation on sliceEvent: cx = sliceX-25 saturating at 0, then clamped to at most 640-SPRITE_SIZE (590). cy = sliceY-25 saturating at 0, then clamped to at most 480-SPRITE_SIZE (430). Use 11-bit/10-bit intermediates so no wrap occurs.
- The clamped corner is stored in a pending register and pending is set.
- A later sliceEvent before the next frameTick overwrites the pending corner. The last event wins.
- States are IDLE and SHOW.
- IDLE: splashActive=0. On frameTick with pending=1, load splashX/Y from the pending corner, load the counter with LIFETIME, clear pending, and go to SHOW.
- SHOW: splashActive=1.
  - On frameTick with pending=1: reload corner and counter (restart), clear pending.
  - On frameTick with pending=0: decrement the counter. On the tick where the counter goes 1->0, go to IDLE.
- splashX/Y change only on frameTick. They are never updated mid-frame.
- If sliceEvent and frameTick occur in the same cycle, frameTick acts on the old pending state. The new event becomes pending for the next frame.
- In-box flag: inBox = splashActive && x>=splashX && x<splashX+SPRITE_SIZE && y>=splashY && y<splashY+SPRITE_SIZE. It is computed from the current x/y.
- inBox passes through a RAM_LATENCY-deep shift register, reset to 0.
- Compositing: colorOut <= (inBox_d && splashColor!=TRANSPARENT) ? splashColor : bgColor.
- Reset asserted mid-SHOW returns to IDLE next edge, drops any pending event, and clears the delay line.

## Timing
- x/y to colorOut: RAM_LATENCY+1 = 3 clocks, of which 1 is the compositing register.
- sliceEvent to visible: the splash becomes visible at the first frameTick strictly after sliceEvent. splashActive and splashX/Y update on the edge following that tick.
- Visible duration: exactly LIFETIME frameTicks from arming, i.e. LIFETIME full frames.
- frameTick, sliceEvent and x/y are all in the clk domain. No synchronisers are needed.

## Test plan
- Arm the splash:
  - Stimulus: sliceEvent with (300,200), then frameTick.
  - Response: splashX=275, splashY=175, splashActive=1 one clock after the tick.
  - Response: pixel (275,175) with splashColor=12'hFA0 gives colorOut=12'hFA0 three clocks after x/y are presented.
  - Response: pixel (325,175) gives bgColor.
- Edge clamping:
  - Stimulus: sliceEvent (10,5).
  - Response: corner (0,0).
  - Stimulus: sliceEvent (635,478).
  - Response: corner (590,430).
  - Response: no wrap on any coordinate.
- Transparency:
  - Stimulus: an inside-box pixel with splashColor=12'h000 and bgColor=12'h35C.
  - Response: colorOut=12'h35C.
- Lifetime:
  - Stimulus: LIFETIME=3 and an armed splash.
  - Response: splashActive stays high through 2 further ticks and falls one clock after the 3rd tick.
  - Response: the next frame's pixels are all bgColor.
- Simultaneous and overwrite events:
  - Stimulus: sliceEvent (100,100) then (400,300) within one frame.
  - Response: armed corner is (375,275).
  - Stimulus: a sliceEvent coincident with frameTick.
  - Response: it arms only at the following tick.
- Reset mid-operation:
  - Stimulus: assert reset for 1 clock while in SHOW with an event pending.
  - Response: splashActive=0, colorOut=0 on the next edge.
  - Response: the following frameTick does not arm the splash.
